// File: rtl/soc_cpu_3_jtag_ocimem_ctrl_if.sv
// Bus between the JTAG debug module / debug RAM (master) and the ocimem
// controller (slave): jdo word, action strobes, RAM port and monitor status.
interface soc_cpu_3_jtag_ocimem_ctrl_if #(
   parameter int unsigned ADDR_W = 8
);
   logic [37:0]       jdo;
   logic              take_action_ocimem_a;
   logic              take_no_action_ocimem_a;
   logic              take_action_ocimem_b;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic              ram_we;
   logic              ram_re;
   logic [31:0]       ram_rdata;
   logic [31:0]       MonDReg;
   logic              monitor_ready;
   logic              monitor_error;
   logic              busy;

   modport master (
      output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
      output ram_rdata,
      input  ram_addr, ram_wdata, ram_we, ram_re,
      input  MonDReg, monitor_ready, monitor_error, busy
   );

   modport slave (
      input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
      input  ram_rdata,
      output ram_addr, ram_wdata, ram_we, ram_re,
      output MonDReg, monitor_ready, monitor_error, busy
   );
endinterface

// File: rtl/soc_cpu_3_jtag_ocimem_ctrl.sv
// Sysclk-side executor of JTAG ocimem commands: address load, debug-RAM
// reads and writes with post-increment, and ready/error status for capture.
module soc_cpu_3_jtag_ocimem_ctrl #(
   parameter int unsigned ADDR_W = 8
) (
   input logic                           clk,
   input logic                           reset,
   soc_cpu_3_jtag_ocimem_ctrl_if.slave   bus
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StRdIssue = 2'd1;
   localparam logic [1:0] StRdCap   = 2'd2;
   localparam logic [1:0] StWrIssue = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       mon_q, mon_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              pend_q, pend_d;

   logic stb_a, stb_n, stb_b;
   logic idle, any_stb, multi_stb, drop;
   logic acc_a, acc_n, acc_b;

   assign stb_a = bus.take_action_ocimem_a;
   assign stb_n = bus.take_no_action_ocimem_a;
   assign stb_b = bus.take_action_ocimem_b;

   assign idle      = (state_q == StIdle);
   assign any_stb   = stb_a | stb_n | stb_b;
   assign multi_stb = (stb_a & stb_n) | (stb_a & stb_b) | (stb_n & stb_b);
   // In IDLE only the losers of the priority pick are dropped; otherwise everything is.
   assign drop      = idle ? multi_stb : any_stb;

   assign acc_a = idle & stb_a;
   assign acc_n = idle & ~stb_a & stb_n;
   assign acc_b = idle & ~stb_a & ~stb_n & stb_b;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mon_d   = mon_q;
      ready_d = ready_q;
      err_d   = err_q;
      pend_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Address-only load completes one edge after it was accepted.
            if (pend_q) ready_d = 1'b1;
            if (acc_a) begin
               addr_d  = bus.jdo[ADDR_W+17:18];
               ready_d = 1'b0;
               if (bus.jdo[35]) state_d = StRdIssue;
               else             pend_d  = 1'b1;
            end else if (acc_n) begin
               ready_d = 1'b0;
               state_d = StRdIssue;
            end else if (acc_b) begin
               wdata_d = bus.jdo[34:3];
               ready_d = 1'b0;
               state_d = StWrIssue;
            end
         end
         StRdIssue: begin
            state_d = StRdCap;
         end
         StRdCap: begin
            mon_d   = bus.ram_rdata;
            ready_d = 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = StIdle;
         end
         StWrIssue: begin
            mon_d   = wdata_q;
            ready_d = 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (drop)                        err_d = 1'b1;
      else if (acc_a && bus.jdo[36])   err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         mon_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mon_q   <= mon_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.ram_addr      = addr_q;
   assign bus.ram_wdata     = wdata_q;
   assign bus.ram_re        = (state_q == StRdIssue);
   assign bus.ram_we        = (state_q == StWrIssue);
   assign bus.MonDReg       = mon_q;
   assign bus.monitor_ready = ready_q;
   assign bus.monitor_error = err_q;
   assign bus.busy          = ~idle;

endmodule
